// File: rtl/anim_pkg.sv
// Shared types and constants for the goose sprite animation sequencer.
package anim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int LUT_DIM = 32;  // sprite bitmap is LUT_DIM x LUT_DIM
    localparam int LUT_AW  = 5;   // log2(LUT_DIM)
    localparam int PIX_W   = 3;   // palette index width
    localparam int FRAME_W = 3;   // frame index width (up to 8 frames)

endpackage

// File: rtl/sprite_addr_gen.sv
// Address stage: tests the beam against the scaled sprite box and converts
// the beam position into registered sprite-local LUT coordinates.
module sprite_addr_gen
    import anim_pkg::*;
#(
    parameter int SPRITE_X0  = 304,
    parameter int SPRITE_Y0  = 224,
    parameter int SCALE_LOG2 = 1,
    parameter int COORD_W    = 10
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_video_active,
    input  logic [COORD_W-1:0] i_hpos,
    input  logic [COORD_W-1:0] i_vpos,
    output logic [LUT_AW-1:0]  o_lut_x,
    output logic [LUT_AW-1:0]  o_lut_y,
    output logic               o_hit
);

    // One extra bit so the subtraction never aliases a left-of-box column
    // onto a valid in-box offset.
    localparam logic [COORD_W:0] X0_C   = (COORD_W+1)'(SPRITE_X0);
    localparam logic [COORD_W:0] Y0_C   = (COORD_W+1)'(SPRITE_Y0);
    localparam logic [COORD_W:0] SPAN_C = (COORD_W+1)'(LUT_DIM << SCALE_LOG2);

    logic [COORD_W:0] w_hpos;
    logic [COORD_W:0] w_vpos;
    logic [COORD_W:0] w_dx;
    logic [COORD_W:0] w_dy;
    logic             w_hit;

    // Offsets from the sprite origin and the in-box test.
    always_comb begin
        w_hpos = {1'b0, i_hpos};
        w_vpos = {1'b0, i_vpos};
        w_dx   = w_hpos - X0_C;
        w_dy   = w_vpos - Y0_C;
        w_hit  = i_video_active
               & (w_hpos >= X0_C) & (w_dx < SPAN_C)
               & (w_vpos >= Y0_C) & (w_dy < SPAN_C);
    end

    // Register the hit flag and the down-scaled coordinates; misses park at 0.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_hit   <= 1'b0;
            o_lut_x <= '0;
            o_lut_y <= '0;
        end else begin
            o_hit   <= w_hit;
            o_lut_x <= w_hit ? w_dx[SCALE_LOG2 +: LUT_AW] : '0;
            o_lut_y <= w_hit ? w_dy[SCALE_LOG2 +: LUT_AW] : '0;
        end
    end

endmodule

// File: rtl/anim_sequencer.sv
// Goose sprite animation sequencer: frame stepping on vsync, sprite
// addressing and a 2-cycle pixel pipeline toward the colour stage.
module anim_sequencer
    import anim_pkg::*;
#(
    parameter int NUM_FRAMES = 8,
    parameter int SPRITE_X0  = 304,
    parameter int SPRITE_Y0  = 224,
    parameter int SCALE_LOG2 = 1,
    parameter int COORD_W    = 10
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic [3:0]         i_speed,
    input  logic               i_vsync_pulse,
    input  logic               i_video_active,
    input  logic [COORD_W-1:0] i_hpos,
    input  logic [COORD_W-1:0] i_vpos,
    input  logic [PIX_W-1:0]   i_pixel_in,
    output logic [FRAME_W-1:0] o_frame_sel,
    output logic [LUT_AW-1:0]  o_lut_x,
    output logic [LUT_AW-1:0]  o_lut_y,
    output logic [PIX_W-1:0]   o_pixel_out,
    output logic               o_sprite_hit,
    output logic               o_loop_done
);

    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [FRAME_W-1:0] r_frame;
    logic [FRAME_W-1:0] w_frame_nxt;
    logic [3:0]         r_tick;
    logic [3:0]         w_tick_nxt;
    logic               r_loop_done;
    logic               w_wrap;

    logic [FRAME_W-1:0] w_adv_frame;
    logic [3:0]         w_adv_tick;
    logic               w_adv_wrap;

    logic               w_hit_d1;
    logic [PIX_W-1:0]   r_pixel;
    logic               r_sprite_hit;

    // What one vsync does to the divider and frame index. ">=" lets a speed
    // reduction below the current count take effect on the next vsync.
    always_comb begin
        w_adv_frame = r_frame;
        w_adv_tick  = r_tick + 4'd1;
        w_adv_wrap  = 1'b0;
        if (r_tick >= i_speed) begin
            w_adv_tick  = '0;
            w_adv_wrap  = (r_frame == LAST_FRAME);
            w_adv_frame = w_adv_wrap ? '0 : r_frame + FRAME_W'(1);
        end
    end

    // FSM next state: IDLE parks at frame 0, PLAY steps, DRAIN steps until
    // the loop wraps so the sprite always comes to rest on frame 0.
    always_comb begin
        w_state_nxt = r_state;
        w_frame_nxt = r_frame;
        w_tick_nxt  = r_tick;
        w_wrap      = 1'b0;
        case (r_state)
            IDLE: begin
                w_frame_nxt = '0;
                w_tick_nxt  = '0;
                if (i_enable) w_state_nxt = PLAY;
            end
            PLAY: begin
                if (i_vsync_pulse) begin
                    w_frame_nxt = w_adv_frame;
                    w_tick_nxt  = w_adv_tick;
                    w_wrap      = w_adv_wrap;
                end
                if (!i_enable) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (i_enable) begin
                    w_state_nxt = PLAY;
                end else if (i_vsync_pulse) begin
                    w_frame_nxt = w_adv_frame;
                    w_tick_nxt  = w_adv_tick;
                    w_wrap      = w_adv_wrap;
                    if (w_adv_wrap) w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_frame_nxt = '0;
                w_tick_nxt  = '0;
            end
        endcase
    end

    // FSM, divider and loop-done pulse registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_frame     <= '0;
            r_tick      <= '0;
            r_loop_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame     <= w_frame_nxt;
            r_tick      <= w_tick_nxt;
            r_loop_done <= w_wrap;
        end
    end

    sprite_addr_gen #(
        .SPRITE_X0  (SPRITE_X0),
        .SPRITE_Y0  (SPRITE_Y0),
        .SCALE_LOG2 (SCALE_LOG2),
        .COORD_W    (COORD_W)
    ) u_addr (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_video_active (i_video_active),
        .i_hpos         (i_hpos),
        .i_vpos         (i_vpos),
        .o_lut_x        (o_lut_x),
        .o_lut_y        (o_lut_y),
        .o_hit          (w_hit_d1)
    );

    // Pixel stage: capture the LUT result for in-box beams, else background.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pixel      <= '0;
            r_sprite_hit <= 1'b0;
        end else begin
            r_pixel      <= w_hit_d1 ? i_pixel_in : '0;
            r_sprite_hit <= w_hit_d1;
        end
    end

    assign o_frame_sel  = r_frame;
    assign o_loop_done  = r_loop_done;
    assign o_pixel_out  = r_pixel;
    assign o_sprite_hit = r_sprite_hit;

endmodule

// File: doc/anim_sequencer.md
Name: anim_sequencer

Overview:
Drives the goose sprite animation. It steps a frame index through the per-frame 32×32 bitmap LUTs, advancing once every N vertical syncs. It converts the VGA beam position into sprite-local LUT coordinates, with placement and power-of-two scaling. It registers the returned 3-bit palette index into a 2-cycle pixel pipeline for the colour stage. It sits between the VGA timing generator and the frame LUT mux.

Parameters:
NUM_FRAMES, 8, number of animation frames (2..8); frame_sel counts 0..NUM_FRAMES-1
SPRITE_X0, 304, screen column of sprite top-left
SPRITE_Y0, 224, screen row of sprite top-left
SCALE_LOG2, 1, sprite magnification 2^SCALE_LOG2 (on-screen size 32<<SCALE_LOG2)
COORD_W, 10, width of hpos/vpos

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
enable  in  1  level; 1 = play animation
speed  in  4  vsync periods per frame minus 1
vsync_pulse  in  1  one-cycle pulse at start of vertical blank
video_active  in  1  beam in visible area
hpos  in  COORD_W  beam column
vpos  in  COORD_W  beam row
pixel_in  in  3  palette index from LUT mux, combinational from lut_x/lut_y/frame_sel
frame_sel  out  3  current animation frame index to LUT mux
lut_x  out  5  sprite-local column (registered)
lut_y  out  5  sprite-local row (registered)
pixel_out  out  3  palette index to colour stage; 0 = background
sprite_hit  out  1  pixel_out is a sprite pixel (aligned with pixel_out)
loop_done  out  1  one-cycle pulse when frame_sel wraps to 0

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, frame_sel=0, tick_cnt=0, lut_x=lut_y=0, pixel_out=0, sprite_hit=0, loop_done=0, pipeline valid bits cleared. Reset asserted mid-animation behaves identically; no partial state survives.
- FSM states: IDLE, PLAY, DRAIN.
  - IDLE: frame_sel held at 0, tick_cnt=0. enable=1 -> PLAY.
  - PLAY: on each vsync_pulse, if tick_cnt >= speed then advance frame and clear tick_cnt, else tick_cnt+1. Using >= means a speed decrease below the current count advances on the next vsync; the counter never wraps.
  - PLAY with enable=0 -> DRAIN.
  - DRAIN: keeps advancing exactly as PLAY until frame_sel wraps to 0, then -> IDLE. enable=1 in DRAIN -> PLAY with frame_sel and tick_cnt untouched.
- Frame advance: frame_sel = (frame_sel==NUM_FRAMES-1) ? 0 : frame_sel+1. loop_done=1 in the cycle after the wrap edge.
- Frame changes occur only on vsync_pulse, so there is never a frame change mid-scan.
- Simultaneous vsync_pulse and enable fall in PLAY: the advance is applied, and the state moves to DRAIN in the same edge.
- Address stage (cycle t -> t+1):
  - dx = hpos-SPRITE_X0, dy = vpos-SPRITE_Y0, computed unsigned at COORD_W+1 bits.
  - hit = video_active & hpos>=SPRITE_X0 & dx<(32<<SCALE_LOG2) & the same for y.
  - lut_x = dx>>SCALE_LOG2 [4:0], lut_y = dy>>SCALE_LOG2 [4:0]; both registered with hit_d1.
  - On a miss, lut_x/lut_y are 0.
- Pixel stage (t+1 -> t+2): pixel_out = hit_d1 ? pixel_in : 0; sprite_hit = hit_d1.
- Total latency hpos/vpos -> pixel_out is 2 clocks; the timing generator compensates.
- frame_sel is stable throughout the visible area, so no pipeline hazard exists on frame change.

Decomposition:
- Package anim_pkg: state enum (IDLE, PLAY, DRAIN); constants LUT_DIM=32, LUT_AW=5, PIX_W=3, FRAME_W=3.
- Sub-module sprite_addr_gen: hit test plus coordinate shift, i.e. the address stage with its register.
- FSM, tick divider and pixel register stay in the top level.

Test Plan:
1. Reset -> enable=1, speed=0, 9 vsync pulses, NUM_FRAMES=8 -> frame_sel steps 1..7,0,1; loop_done pulses once, after the 8th vsync.
2. speed=2, enable=1 -> frame_sel advances on vsync 3, 6, 9; at speed=5 with tick_cnt=4, write speed=1 -> advance on the next vsync.
3. Enable falls at frame_sel=5 -> DRAIN. Frames advance 6,7,0, then IDLE; frame_sel stays at 0 under further vsyncs. Enable=1 at frame 6 during DRAIN -> PLAY continues from 6.
4. SCALE_LOG2=1, hpos=305, vpos=287, video_active=1 -> two clocks later lut_x=0, lut_y=31 (registered the cycle before), pixel_out=pixel_in, sprite_hit=1.
5. hpos=303 and hpos=368 at vpos=230 -> sprite_hit=0, pixel_out=0. video_active=0 inside the sprite box -> pixel_out=0.
6. rst_n=0 for one cycle mid-PLAY at frame 4 with pending hits in the pipe -> next cycle all outputs 0, state IDLE, frame_sel=0.
